// File: rtl/exe_mem_skid_pkg.sv
// Shared definitions for the EXE->MEM skid stage: FSM state encoding and
// the field layout of the packed EXE->MEM payload.
package exe_mem_skid_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } stage_state_e;

   localparam int WADDR_W    = 5;
   localparam int WE_W       = 1;
   localparam int WDATA_W    = 32;
   localparam int MEM_WE_W   = 1;
   localparam int MEM_ADDR_W = 32;
   localparam int MEM_DATA_W = 32;
   localparam int MEM_OP_W   = 4;

   // Fields are packed MSB-first in the order listed above.
   localparam int MEM_OP_LSB   = 0;
   localparam int MEM_DATA_LSB = MEM_OP_LSB + MEM_OP_W;
   localparam int MEM_ADDR_LSB = MEM_DATA_LSB + MEM_DATA_W;
   localparam int MEM_WE_LSB   = MEM_ADDR_LSB + MEM_ADDR_W;
   localparam int WDATA_LSB    = MEM_WE_LSB + MEM_WE_W;
   localparam int WE_LSB       = WDATA_LSB + WDATA_W;
   localparam int WADDR_LSB    = WE_LSB + WE_W;
   localparam int PKG_PAYLOAD_W = WADDR_LSB + WADDR_W;

   function automatic logic [PKG_PAYLOAD_W-1:0] pack_payload(
      input logic [WADDR_W-1:0]    waddr,
      input logic                  we,
      input logic [WDATA_W-1:0]    wdata,
      input logic                  mem_we,
      input logic [MEM_ADDR_W-1:0] mem_addr,
      input logic [MEM_DATA_W-1:0] mem_data,
      input logic [MEM_OP_W-1:0]   mem_op
   );
      return {waddr, we, wdata, mem_we, mem_addr, mem_data, mem_op};
   endfunction

endpackage

// File: rtl/stage_stall_cnt.sv
// Saturating event counter used to measure back-pressure cycles on the
// EXE->MEM stage; holds at all-ones and clears only on reset.
module stage_stall_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (inc && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/exe_mem_skid.sv
// EXE->MEM pipeline register with a one-entry skid buffer (main + skid).
// Optional back-pressure counter enabled by macro STAGE_STALL_CNT_EN.
module exe_mem_skid
   import exe_mem_skid_pkg::*;
#(
   parameter int PAYLOAD_W = PKG_PAYLOAD_W,
   parameter int CNT_W     = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [PAYLOAD_W-1:0] in_data_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [PAYLOAD_W-1:0] out_data_o,
`ifdef STAGE_STALL_CNT_EN
   output logic [CNT_W-1:0]     stall_cnt_o,
`endif
   output logic [1:0]           state_o
);

   // Valid/ready: a payload crosses a side only on a rising edge where that
   // side's valid and ready are both 1; ready/valid outputs come from state only.

   stage_state_e         state, state_next;
   logic [PAYLOAD_W-1:0] main_q, skid_q;
   logic                 load_main_in, load_main_skid, load_skid;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next     = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state)
         ST_EMPTY: begin
            if (in_valid_i) begin
               load_main_in = 1'b1;
               state_next   = ST_ONE;
            end
         end
         ST_ONE: begin
            case ({in_valid_i, out_ready_i})
               2'b11: load_main_in = 1'b1;
               2'b01: state_next = ST_EMPTY;
               2'b10: begin
                  load_skid  = 1'b1;
                  state_next = ST_FULL;
               end
               default: ;
            endcase
         end
         ST_FULL: begin
            if (out_ready_i) begin
               load_main_skid = 1'b1;
               state_next     = ST_ONE;
            end
         end
         default: state_next = ST_EMPTY;
      endcase
      // A kill drops everything, including any payload offered this cycle.
      if (flush_i) begin
         state_next     = ST_EMPTY;
         load_main_in   = 1'b0;
         load_main_skid = 1'b0;
         load_skid      = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main_in) begin
            main_q <= in_data_i;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_data_i;
         end
      end
   end

   assign in_ready_o  = (state == ST_EMPTY) || (state == ST_ONE);
   assign out_valid_o = (state == ST_ONE) || (state == ST_FULL);
   assign out_data_o  = main_q;
   assign state_o     = state;

`ifdef STAGE_STALL_CNT_EN
   stage_stall_cnt #(
      .CNT_W(CNT_W)
   ) u_stall_cnt (
      .clk (clk_i),
      .rst (rst_i),
      .inc (out_valid_o && !out_ready_i),
      .cnt (stall_cnt_o)
   );
`else
   localparam int unused_cnt_w = CNT_W;
`endif

endmodule
